// File: rtl/trace_fabric_h2t_channel_adap.sv
// Host-to-trace Avalon-ST channel adapter: narrows the channel field,
// discards packets on out-of-range channels, registered skid-buffered output.
module trace_fabric_h2t_channel_adap #(
  parameter int DATA_W        = 8,
  parameter int IN_CHANNEL_W  = 8,
  parameter int OUT_CHANNEL_W = 2,
  parameter int MAX_CHANNEL   = 3,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [IN_CHANNEL_W-1:0]  in_channel,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [OUT_CHANNEL_W-1:0] out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CNT_W-1:0]         drop_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [IN_CHANNEL_W-1:0] MAX_CH =
    IN_CHANNEL_W'(MAX_CHANNEL);

  state_t                   state_q, state_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic [OUT_CHANNEL_W-1:0] out_chan_q, out_chan_d;
  logic                     out_sop_q, out_sop_d;
  logic                     out_eop_q, out_eop_d;
  logic                     skd_valid_q, skd_valid_d;
  logic [DATA_W-1:0]        skd_data_q, skd_data_d;
  logic [OUT_CHANNEL_W-1:0] skd_chan_q, skd_chan_d;
  logic                     skd_sop_q, skd_sop_d;
  logic                     skd_eop_q, skd_eop_d;
  logic [CNT_W-1:0]         drop_cnt_q, drop_cnt_d;

  logic                     acc;
  logic                     legal;
  logic                     fwd;
  logic                     drop_start;
  logic                     out_free;
  logic [OUT_CHANNEL_W-1:0] in_chan_lo;

  assign in_chan_lo = in_channel[OUT_CHANNEL_W-1:0];

  // Packet framing: only the first beat's full-width channel decides.
  always_comb begin
    acc        = in_valid && in_ready_q;
    legal      = (in_channel <= MAX_CH);
    fwd        = 1'b0;
    drop_start = 1'b0;
    state_d    = state_q;
    if (acc) begin
      unique case (state_q)
        IDLE: begin
          if (legal) begin
            fwd = 1'b1;
            if (!in_endofpacket) state_d = PASS;
          end else begin
            drop_start = 1'b1;
            if (!in_endofpacket) state_d = DROP;
          end
        end
        PASS: begin
          fwd = 1'b1;
          if (in_endofpacket) state_d = IDLE;
        end
        DROP: begin
          if (in_endofpacket) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output register plus one-entry skid; skid always drains first.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    skd_valid_d = skd_valid_q;
    skd_data_d  = skd_data_q;
    skd_chan_d  = skd_chan_q;
    skd_sop_d   = skd_sop_q;
    skd_eop_d   = skd_eop_q;
    out_free    = !out_valid_q || out_ready;
    if (out_free) begin
      if (skd_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = skd_data_q;
        out_chan_d  = skd_chan_q;
        out_sop_d   = skd_sop_q;
        out_eop_d   = skd_eop_q;
        skd_valid_d = fwd;
        if (fwd) begin
          skd_data_d = in_data;
          skd_chan_d = in_chan_lo;
          skd_sop_d  = in_startofpacket;
          skd_eop_d  = in_endofpacket;
        end
      end else if (fwd) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
        out_chan_d  = in_chan_lo;
        out_sop_d   = in_startofpacket;
        out_eop_d   = in_endofpacket;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (fwd) begin
      skd_valid_d = 1'b1;
      skd_data_d  = in_data;
      skd_chan_d  = in_chan_lo;
      skd_sop_d   = in_startofpacket;
      skd_eop_d   = in_endofpacket;
    end
    in_ready_d = !skd_valid_d;
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_start && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      skd_valid_q <= 1'b0;
      skd_data_q  <= '0;
      skd_chan_q  <= '0;
      skd_sop_q   <= 1'b0;
      skd_eop_q   <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      skd_valid_q <= skd_valid_d;
      skd_data_q  <= skd_data_d;
      skd_chan_q  <= skd_chan_d;
      skd_sop_q   <= skd_sop_d;
      skd_eop_q   <= skd_eop_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_channel       = out_chan_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign drop_count        = drop_cnt_q;

endmodule
